// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM->WB stage: result-mux select, load funct3 codes,
// FSM states and the buffered writeback entry.
package wb_pkg;

  localparam int WB_WIDTH  = 32;
  localparam int WB_REG_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WB_WIDTH-1:0]  alu;
    logic [WB_WIDTH-1:0]  rdata;
    logic [WB_WIDTH-1:0]  pc4;
    logic [WB_WIDTH-1:0]  imm;
    result_src_e          src;
    logic                 regwrite;
    logic [WB_REG_AW-1:0] rd;
    logic                 misalign;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side and WB-side signals of the MEM->WB stage. Both sides use plain
// valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
interface mem_wb_stage_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              Flush;
  logic              InValid;
  logic              InReady;
  logic [WIDTH-1:0]  ALUResultM;
  logic [WIDTH-1:0]  ReadDataM;
  logic [WIDTH-1:0]  PCPlus4M;
  logic [WIDTH-1:0]  ImmExtM;
  logic [1:0]        ResultSrcM;
  logic [2:0]        Funct3M;
  logic              RegWriteM;
  logic [REG_AW-1:0] RdM;

  logic              OutValid;
  logic              OutReady;
  logic [WIDTH-1:0]  ALUResultW;
  logic [WIDTH-1:0]  ReadDataW;
  logic [WIDTH-1:0]  PCPlus4W;
  logic [WIDTH-1:0]  ImmExtW;
  logic [1:0]        ResultSrcW;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic              MisalignW;

  modport master (
    output Flush, InValid, ALUResultM, ReadDataM, PCPlus4M, ImmExtM,
           ResultSrcM, Funct3M, RegWriteM, RdM, OutReady,
    input  InReady, OutValid, ALUResultW, ReadDataW, PCPlus4W, ImmExtW,
           ResultSrcW, RegWriteW, RdW, MisalignW
  );

  modport slave (
    input  Flush, InValid, ALUResultM, ReadDataM, PCPlus4M, ImmExtM,
           ResultSrcM, Funct3M, RegWriteM, RdM, OutReady,
    output InReady, OutValid, ALUResultW, ReadDataW, PCPlus4W, ImmExtW,
           ResultSrcW, RegWriteW, RdW, MisalignW
  );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load-data extraction: picks the byte/half lane selected by the
// low address bits, sign- or zero-extends it, and flags misaligned halves/words.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = raw[{addr, 3'b000} +: 8];
  assign half_v = raw[{addr[1], 4'b0000} +: 16];

  always_comb begin
    data     = raw;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_v[7]}}, byte_v};
      F3_LBU: data = {24'h0, byte_v};
      F3_LH: begin
        data     = {{16{half_v[15]}}, half_v};
        misalign = addr[0];
      end
      F3_LHU: begin
        data     = {16'h0, half_v};
        misalign = addr[0];
      end
      F3_LW:   misalign = (addr != 2'b00);
      // Undefined encodings behave as an aligned LW.
      default: misalign = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: 2-entry skid buffer (head/tail entry registers) that
// extends load data on entry and presents the head entry to the writeback mux.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           reset,
  mem_wb_stage_if.slave  bus,
  output state_e         dbg_state
);
  if (WIDTH != WB_WIDTH || REG_AW != WB_REG_AW) begin : g_bad_param
    $error("mem_wb_stage: load extension is defined only for WIDTH=32, REG_AW=5");
  end

  state_e    state_q, state_d;
  wb_entry_t head_q, tail_q, new_e;
  logic      accept, pop, is_load, ld_mis;
  logic [31:0] ld_data;

  load_extend u_load_extend (
    .raw      (bus.ReadDataM),
    .addr     (bus.ALUResultM[1:0]),
    .funct3   (bus.Funct3M),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  assign is_load = (bus.ResultSrcM == RES_LOAD);

  always_comb begin
    new_e          = '0;
    new_e.alu      = bus.ALUResultM;
    new_e.rdata    = is_load ? ld_data : bus.ReadDataM;
    new_e.pc4      = bus.PCPlus4M;
    new_e.imm      = bus.ImmExtM;
    new_e.src      = result_src_e'(bus.ResultSrcM);
    new_e.regwrite = bus.RegWriteM;
    new_e.rd       = bus.RdM;
    new_e.misalign = is_load & ld_mis;
  end

  // Handshake flags come from the state register only, never from the other side.
  assign bus.InReady  = (state_q != ST_FULL);
  assign bus.OutValid = (state_q != ST_EMPTY);
  assign accept       = bus.InValid & bus.InReady;
  assign pop          = bus.OutValid & bus.OutReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_d = ST_FULL;
          else if (pop && !accept) state_d = ST_EMPTY;
        end
        ST_FULL: if (pop) state_d = ST_ONE;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry registers are only written on a transfer, so the head holds while idle
  // or stalled. A flush only resets the state; stale data stays visible but invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!bus.Flush) begin
      case (state_q)
        ST_EMPTY: if (accept) head_q <= new_e;
        ST_ONE: begin
          if (accept && pop) head_q <= new_e;
          else if (accept)   tail_q <= new_e;
        end
        ST_FULL: if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  assign bus.ALUResultW = head_q.alu;
  assign bus.ReadDataW  = head_q.rdata;
  assign bus.PCPlus4W   = head_q.pc4;
  assign bus.ImmExtW    = head_q.imm;
  assign bus.ResultSrcW = head_q.src;
  assign bus.RegWriteW  = head_q.regwrite & bus.OutValid;
  assign bus.RdW        = head_q.rd;
  assign bus.MisalignW  = head_q.misalign;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a FIFO scoreboard of expected entries,
// fed by an independent load-extension model, plus directed literal checks.
module tb_mem_wb_stage;
  import wb_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic        rw;
    logic [4:0]  rd;
  } beat_t;

  logic   clk;
  logic   reset;
  state_e dbg_state;

  mem_wb_stage_if #(.WIDTH(32), .REG_AW(5)) u_if ();

  mem_wb_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (u_if.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int pops;
  wb_entry_t exp_q[$];
  wb_entry_t last_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic wb_entry_t model(input beat_t b);
    wb_entry_t   m;
    logic [31:0] sh;
    int          a;
    a = int'(b.alu[1:0]);
    m = '0;
    m.alu = b.alu; m.pc4 = b.pc4; m.imm = b.imm;
    m.src = result_src_e'(b.src); m.regwrite = b.rw; m.rd = b.rd;
    m.rdata = b.rdata;
    if (b.src == 2'b01) begin
      case (b.f3)
        3'b000: begin sh = b.rdata >> (8 * a); m.rdata = {{24{sh[7]}}, sh[7:0]}; end
        3'b100: m.rdata = (b.rdata >> (8 * a)) & 32'h0000_00FF;
        3'b001: begin
          sh = b.rdata >> ((a >= 2) ? 16 : 0);
          m.rdata = {{16{sh[15]}}, sh[15:0]};
          m.misalign = (a % 2) == 1;
        end
        3'b101: begin
          sh = b.rdata >> ((a >= 2) ? 16 : 0);
          m.rdata = sh & 32'h0000_FFFF;
          m.misalign = (a % 2) == 1;
        end
        3'b010: m.misalign = (a != 0);
        default: m.misalign = 1'b0;
      endcase
    end
    return m;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    logic [2:0] f3_tab [6];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
    b.alu   = $urandom;
    b.rdata = $urandom;
    b.pc4   = $urandom;
    b.imm   = $urandom;
    b.src   = 2'($urandom_range(0, 3));
    b.f3    = f3_tab[$urandom_range(0, 5)];
    b.rw    = 1'($urandom_range(0, 1));
    b.rd    = 5'($urandom_range(0, 31));
    return b;
  endfunction

  // One clock cycle: drive at negedge, check outputs against the model, update the
  // scoreboard with this cycle's transfers, advance to the next negedge.
  task automatic cycle(input logic iv, input beat_t b, input logic ordy, input logic fl);
    logic accepted;
    u_if.InValid    = iv;
    u_if.ALUResultM = b.alu;
    u_if.ReadDataM  = b.rdata;
    u_if.PCPlus4M   = b.pc4;
    u_if.ImmExtM    = b.imm;
    u_if.ResultSrcM = b.src;
    u_if.Funct3M    = b.f3;
    u_if.RegWriteM  = b.rw;
    u_if.RdM        = b.rd;
    u_if.OutReady   = ordy;
    u_if.Flush      = fl;
    #1;
    chk("out_valid", 64'(u_if.OutValid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(u_if.InReady), 64'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      chk("alu_w", 64'(u_if.ALUResultW), 64'(exp_q[0].alu));
      chk("rdata_w", 64'(u_if.ReadDataW), 64'(exp_q[0].rdata));
      chk("pc4_w", 64'(u_if.PCPlus4W), 64'(exp_q[0].pc4));
      chk("imm_w", 64'(u_if.ImmExtW), 64'(exp_q[0].imm));
      chk("src_w", 64'(u_if.ResultSrcW), 64'(exp_q[0].src));
      chk("regwrite_w", 64'(u_if.RegWriteW), 64'(exp_q[0].regwrite));
      chk("rd_w", 64'(u_if.RdW), 64'(exp_q[0].rd));
      chk("misalign_w", 64'(u_if.MisalignW), 64'(exp_q[0].misalign));
    end else begin
      chk("regwrite_idle", 64'(u_if.RegWriteW), 64'd0);
      chk("hold_alu_idle", 64'(u_if.ALUResultW), 64'(last_e.alu));
    end
    accepted = iv && (exp_q.size() < 2);
    if (fl) begin
      if (exp_q.size() != 0) last_e = exp_q[0];
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ordy) begin
        last_e = exp_q.pop_front();
        pops++;
      end
      if (accepted) exp_q.push_back(model(b));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [1:0] a,
                           input logic [31:0] exp_d, input logic exp_m);
    beat_t b;
    b = '0;
    b.rdata = 32'h80F1_7F82;
    b.alu   = {30'h0000_1000, a};
    b.src   = 2'b01;
    b.f3    = f3;
    b.rw    = 1'b1;
    b.rd    = 5'd7;
    cycle(1'b1, b, 1'b0, 1'b0);
    chk("ld_lit_data", 64'(u_if.ReadDataW), 64'(exp_d));
    chk("ld_lit_mis", 64'(u_if.MisalignW), 64'(exp_m));
    drain(4);
  endtask

  initial begin
    beat_t b;
    checks = 0; failures = 0; pops = 0;
    last_e = '0;
    u_if.Flush = 1'b0; u_if.InValid = 1'b0; u_if.OutReady = 1'b0;
    u_if.ALUResultM = '0; u_if.ReadDataM = '0; u_if.PCPlus4M = '0; u_if.ImmExtM = '0;
    u_if.ResultSrcM = '0; u_if.Funct3M = '0; u_if.RegWriteM = 1'b0; u_if.RdM = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(u_if.OutValid), 64'd0);
    chk("rst_in_ready", 64'(u_if.InReady), 64'd1);
    chk("rst_rdata_w", 64'(u_if.ReadDataW), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
    reset = 1'b0;
    @(negedge clk);

    load_case(3'b000, 2'b01, 32'h0000_007F, 1'b0);
    load_case(3'b000, 2'b00, 32'hFFFF_FF82, 1'b0);
    load_case(3'b100, 2'b00, 32'h0000_0082, 1'b0);
    load_case(3'b001, 2'b10, 32'hFFFF_80F1, 1'b0);
    load_case(3'b101, 2'b10, 32'h0000_80F1, 1'b0);
    load_case(3'b001, 2'b01, 32'h0000_7F82, 1'b1);
    load_case(3'b010, 2'b10, 32'h80F1_7F82, 1'b1);
    load_case(3'b111, 2'b11, 32'h80F1_7F82, 1'b0);

    // ResultSrc sweep with distinct mux inputs
    for (int s = 0; s < 4; s++) begin
      b = '0;
      b.alu = 32'hA000_0000 + s; b.rdata = 32'hB000_0010 + s;
      b.pc4 = 32'hC000_0000 + s; b.imm = 32'hD000_0000 + s;
      b.src = 2'(s); b.f3 = 3'b010; b.rw = 1'b1; b.rd = 5'(s + 1);
      cycle(1'b1, b, 1'b0, 1'b0);
      chk("sweep_src", 64'(u_if.ResultSrcW), 64'(s));
      drain(4);
    end

    // Backpressure: three beats offered, only two accepted
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    chk("bp_in_ready", 64'(u_if.InReady), 64'd0);
    chk("bp_state", 64'(dbg_state), 64'(ST_FULL));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_ready_after_pop", 64'(u_if.InReady), 64'd1);
    drain(4);

    // Streaming at one beat per cycle
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, rand_beat(), 1'b1, 1'b0);
      chk("stream_state", 64'(dbg_state), 64'(ST_ONE));
    end
    drain(4);

    // Flush in FULL with a beat offered in the same cycle
    cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    cycle(1'b1, rand_beat(), 1'b1, 1'b1);
    chk("flush_state", 64'(dbg_state), 64'(ST_EMPTY));
    cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    drain(4);

    // Flush while not full keeps InReady high
    cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    u_if.Flush = 1'b1;
    #1 chk("flush_in_ready", 64'(u_if.InReady), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("flush1_state", 64'(dbg_state), 64'(ST_EMPTY));

    // Random traffic
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), rand_beat(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    drain(4);

    // Asynchronous reset mid-FULL, checked before any clock edge
    cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    cycle(1'b1, rand_beat(), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(u_if.OutValid), 64'd0);
    chk("arst_in_ready", 64'(u_if.InReady), 64'd1);
    chk("arst_regwrite", 64'(u_if.RegWriteW), 64'd0);
    chk("arst_alu_w", 64'(u_if.ALUResultW), 64'd0);
    exp_q.delete();
    last_e = '0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, rand_beat(), 1'b1, 1'b0);
    drain(4);

    chk("pop_count_nonzero", 64'(pops > 40), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
